// File: rtl/router_inject_ni.sv
// Local NI injection stage: buffers client words, prepends a head flit and feeds
// router input port 0 under per-VC credit flow control.
module router_inject_ni #(
  parameter int NUM_VCS      = 4,
  parameter int VC_BUF_DEPTH = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 4
) (
  input  logic                                            clk,
  input  logic                                            reset,
  input  logic [ADDR_WIDTH-1:0]                           router_address,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic                                            in_last,
  input  logic [ADDR_WIDTH-1:0]                           in_dest,
  input  logic [$clog2(NUM_VCS)-1:0]                      in_vc,
  output logic [DATA_WIDTH+$clog2(NUM_VCS)+3:0]           channel_out,
  input  logic [$clog2(NUM_VCS):0]                        flow_ctrl_in,
  output logic                                            pkt_sent,
  output logic                                            error,
  output logic [1:0]                                      state_dbg,
  output logic [NUM_VCS*$clog2(VC_BUF_DEPTH+1)-1:0]       credit_dbg
);
  localparam int VCW    = $clog2(NUM_VCS);
  localparam int CW     = $clog2(VC_BUF_DEPTH + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int FLIT_W = DATA_WIDTH + VCW + 4;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HEAD = 2'd1, S_BODY = 2'd2} state_t;

  // Client handshake: a word transfers on a rising edge where in_valid && in_ready;
  // in_ready depends only on FIFO occupancy, never on in_valid.
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic                  fifo_last [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_dest [FIFO_DEPTH];
  logic [VCW-1:0]        fifo_vc   [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  push, pop, fifo_empty;

  state_t                state, state_next;
  logic [VCW-1:0]        cur_vc;
  logic [ADDR_WIDTH-1:0] cur_dest;
  logic [CW-1:0]         credit [NUM_VCS];
  logic                  credit_ok, latch_pkt, send, tail_send;
  logic [FLIT_W-1:0]     flit_next;

  assign in_ready   = (count != (PW+1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);
  assign credit_ok  = (credit[cur_vc] != '0);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= in_data;
      fifo_last[wr_ptr] <= in_last;
      fifo_dest[wr_ptr] <= in_dest;
      fifo_vc[wr_ptr]   <= in_vc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // A tail pop always returns to IDLE, so the next packet's head is examined a cycle later.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (!fifo_empty) state_next = S_HEAD;
      S_HEAD:  if (credit_ok) state_next = S_BODY;
      S_BODY:  if (!fifo_empty && credit_ok && fifo_last[rd_ptr]) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    latch_pkt = 1'b0;
    send      = 1'b0;
    pop       = 1'b0;
    tail_send = 1'b0;
    flit_next = '0;
    case (state)
      S_IDLE: latch_pkt = !fifo_empty;
      S_HEAD: begin
        if (credit_ok) begin
          send      = 1'b1;
          flit_next = {1'b1, 1'b1, 1'b0, cur_vc, 1'b0, cur_dest, router_address,
                       {(DATA_WIDTH-2*ADDR_WIDTH){1'b0}}};
        end
      end
      S_BODY: begin
        if (!fifo_empty && credit_ok) begin
          send      = 1'b1;
          pop       = 1'b1;
          tail_send = fifo_last[rd_ptr];
          flit_next = {1'b1, 1'b0, fifo_last[rd_ptr], cur_vc, 1'b0, fifo_data[rd_ptr]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      channel_out <= '0;
      pkt_sent    <= 1'b0;
      cur_vc      <= '0;
      cur_dest    <= '0;
    end else begin
      channel_out <= flit_next;
      pkt_sent    <= tail_send;
      if (latch_pkt) begin
        cur_vc   <= fifo_vc[rd_ptr];
        cur_dest <= fifo_dest[rd_ptr];
      end
    end
  end

  // Same-cycle return and spend on one VC cancel; a lone return at full is an overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CW'(VC_BUF_DEPTH);
      error <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        if (flow_ctrl_in[VCW] && (flow_ctrl_in[VCW-1:0] == VCW'(v)) &&
            !(send && (cur_vc == VCW'(v)))) begin
          if (credit[v] == CW'(VC_BUF_DEPTH)) error <= 1'b1;
          else credit[v] <= credit[v] + CW'(1);
        end else if (send && (cur_vc == VCW'(v)) &&
                     !(flow_ctrl_in[VCW] && (flow_ctrl_in[VCW-1:0] == VCW'(v)))) begin
          credit[v] <= credit[v] - CW'(1);
        end
      end
    end
  end

  always_comb begin
    credit_dbg = '0;
    for (int v = 0; v < NUM_VCS; v++) credit_dbg[v*CW +: CW] = credit[v];
  end
endmodule

// File: tb/tb_router_inject_ni.sv
// Directed bench for router_inject_ni: flit format, latency, credits, backpressure, reset.
module tb_router_inject_ni;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  router_address;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic [3:0]  in_dest;
  logic [1:0]  in_vc;
  logic [69:0] channel_out;
  logic [2:0]  flow_ctrl_in;
  logic        pkt_sent;
  logic        error;
  logic [1:0]  state_dbg;
  logic [15:0] credit_dbg;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [70:0] rx_q[$];

  router_inject_ni dut (
    .clk(clk), .reset(reset), .router_address(router_address),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .in_dest(in_dest), .in_vc(in_vc), .channel_out(channel_out),
    .flow_ctrl_in(flow_ctrl_in), .pkt_sent(pkt_sent), .error(error),
    .state_dbg(state_dbg), .credit_dbg(credit_dbg)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (channel_out[69]) rx_q.push_back({pkt_sent, channel_out});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, err_cnt=%0d", err_cnt);
    $fatal(1);
  end

  function automatic logic [69:0] head_flit(logic [1:0] vc, logic [3:0] dst, logic [3:0] src);
    return {3'b110, vc, 1'b0, dst, src, 56'h0};
  endfunction

  function automatic logic [69:0] body_flit(logic tail, logic [1:0] vc, logic [63:0] d);
    return {2'b10, tail, vc, 1'b0, d};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [63:0] d, input logic l, input logic [3:0] dst,
                           input logic [1:0] vc);
    bit ok;
    int n;
    in_valid = 1'b1; in_data = d; in_last = l; in_dest = dst; in_vc = vc;
    n = 0;
    do begin
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1; n++;
    end while (!ok && n < 50);
    in_valid = 1'b0;
    vec_cnt++;
    if (!ok) begin err_cnt++; $display("FAIL push_accept: in_ready=0 for 50 cycles, required 1"); end
  endtask

  task automatic return_credit(input logic [1:0] vc, input int n);
    flow_ctrl_in = {1'b1, vc};
    repeat (n) tick();
    flow_ctrl_in = 3'b000;
  endtask

  task automatic wait_flits(input int n);
    int k = 0;
    while (rx_q.size() < n && k < 100) begin tick(); k++; end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; in_last = 1'b1; in_dest = 4'h1; in_vc = 2'd0;
    repeat (3) tick();
    vec_cnt++; if (channel_out !== 70'h0) begin err_cnt++; $display("FAIL reset_channel_out: got %h required 0", channel_out); end
    vec_cnt++; if (error !== 1'b0) begin err_cnt++; $display("FAIL reset_error: got %b required 0", error); end
    vec_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    vec_cnt++; if (pkt_sent !== 1'b0) begin err_cnt++; $display("FAIL reset_pkt_sent: got %b required 0", pkt_sent); end
    vec_cnt++; if (state_dbg !== 2'd0) begin err_cnt++; $display("FAIL reset_state: got %0d required 0", state_dbg); end
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    vec_cnt++; if (credit_dbg !== 16'h8888) begin err_cnt++; $display("FAIL reset_credits: got %h required 8888", credit_dbg); end
    vec_cnt++; if (channel_out !== 70'h0) begin err_cnt++; $display("FAIL reset_no_push: got %h required 0", channel_out); end
  endtask

  task automatic test_single_word();
    rx_q.delete();
    push_word(64'hA5A5, 1'b1, 4'd9, 2'd1);
    vec_cnt++; if (channel_out !== 70'h0) begin err_cnt++; $display("FAIL single_lat0: got %h required 0", channel_out); end
    tick();
    vec_cnt++; if (channel_out !== 70'h0) begin err_cnt++; $display("FAIL single_lat1: got %h required 0", channel_out); end
    tick();
    vec_cnt++; if (channel_out !== {3'b110, 2'b01, 1'b0, 8'h93, 56'h0}) begin err_cnt++; $display("FAIL single_head: got %h required %h", channel_out, {3'b110, 2'b01, 1'b0, 8'h93, 56'h0}); end
    tick();
    vec_cnt++; if (channel_out !== {3'b101, 2'b01, 1'b0, 64'hA5A5}) begin err_cnt++; $display("FAIL single_body: got %h required %h", channel_out, {3'b101, 2'b01, 1'b0, 64'hA5A5}); end
    vec_cnt++; if (pkt_sent !== 1'b1) begin err_cnt++; $display("FAIL single_pkt_sent: got %b required 1", pkt_sent); end
    tick();
    vec_cnt++; if (channel_out !== 70'h0) begin err_cnt++; $display("FAIL single_idle_after: got %h required 0", channel_out); end
    vec_cnt++; if (pkt_sent !== 1'b0) begin err_cnt++; $display("FAIL single_pkt_pulse: got %b required 0", pkt_sent); end
    vec_cnt++; if (credit_dbg[7:4] !== 4'd6) begin err_cnt++; $display("FAIL single_credit_dec: got %0d required 6", credit_dbg[7:4]); end
    return_credit(2'd1, 2);
    vec_cnt++; if (credit_dbg[7:4] !== 4'd8) begin err_cnt++; $display("FAIL single_credit_ret: got %0d required 8", credit_dbg[7:4]); end
    vec_cnt++; if (error !== 1'b0) begin err_cnt++; $display("FAIL single_error: got %b required 0", error); end
  endtask

  task automatic test_credit_exhaust();
    rx_q.delete();
    for (int i = 0; i < 10; i++) push_word(64'h100 + 64'(i), (i == 9), 4'h5, 2'd2);
    repeat (10) tick();
    vec_cnt++; if (rx_q.size() !== 8) begin err_cnt++; $display("FAIL exhaust_count: got %0d flits required 8", rx_q.size()); end
    vec_cnt++; if (channel_out[69] !== 1'b0) begin err_cnt++; $display("FAIL exhaust_stall: valid %b required 0", channel_out[69]); end
    vec_cnt++; if (credit_dbg[11:8] !== 4'd0) begin err_cnt++; $display("FAIL exhaust_credit: got %0d required 0", credit_dbg[11:8]); end
    if (rx_q.size() >= 8) begin
      vec_cnt++; if (rx_q[0] !== {1'b0, head_flit(2'd2, 4'h5, 4'h3)}) begin err_cnt++; $display("FAIL exhaust_head: got %h required %h", rx_q[0], {1'b0, head_flit(2'd2, 4'h5, 4'h3)}); end
      for (int k = 1; k < 8; k++) begin
        vec_cnt++;
        if (rx_q[k] !== {1'b0, body_flit(1'b0, 2'd2, 64'h100 + 64'(k - 1))}) begin
          err_cnt++; $display("FAIL exhaust_body%0d: got %h required %h", k, rx_q[k], {1'b0, body_flit(1'b0, 2'd2, 64'h100 + 64'(k - 1))});
        end
      end
    end
    return_credit(2'd2, 3);
    wait_flits(11);
    repeat (3) tick();
    vec_cnt++; if (rx_q.size() !== 11) begin err_cnt++; $display("FAIL resume_count: got %0d flits required 11", rx_q.size()); end
    if (rx_q.size() >= 11) begin
      for (int k = 8; k < 11; k++) begin
        vec_cnt++;
        if (rx_q[k] !== {(k == 10), body_flit((k == 10), 2'd2, 64'h100 + 64'(k - 1))}) begin
          err_cnt++; $display("FAIL resume_body%0d: got %h required %h", k, rx_q[k], {(k == 10), body_flit((k == 10), 2'd2, 64'h100 + 64'(k - 1))});
        end
      end
    end
    vec_cnt++; if (credit_dbg[11:8] !== 4'd0) begin err_cnt++; $display("FAIL resume_credit: got %0d required 0", credit_dbg[11:8]); end
    return_credit(2'd2, 8);
    vec_cnt++; if (credit_dbg !== 16'h8888) begin err_cnt++; $display("FAIL exhaust_restore: got %h required 8888", credit_dbg); end
  endtask

  task automatic test_simultaneous();
    rx_q.delete();
    push_word(64'h77, 1'b1, 4'hC, 2'd3);
    tick();
    flow_ctrl_in = 3'b111;
    tick();
    flow_ctrl_in = 3'b000;
    vec_cnt++; if (channel_out !== head_flit(2'd3, 4'hC, 4'h3)) begin err_cnt++; $display("FAIL simul_head: got %h required %h", channel_out, head_flit(2'd3, 4'hC, 4'h3)); end
    vec_cnt++; if (credit_dbg[15:12] !== 4'd8) begin err_cnt++; $display("FAIL simul_unchanged: got %0d required 8", credit_dbg[15:12]); end
    vec_cnt++; if (error !== 1'b0) begin err_cnt++; $display("FAIL simul_no_error: got %b required 0", error); end
    tick();
    vec_cnt++; if (credit_dbg[15:12] !== 4'd7) begin err_cnt++; $display("FAIL simul_body_dec: got %0d required 7", credit_dbg[15:12]); end
    return_credit(2'd3, 1);
    vec_cnt++; if (credit_dbg[15:12] !== 4'd8 || error !== 1'b0) begin err_cnt++; $display("FAIL simul_refill: credit %0d error %b required 8 0", credit_dbg[15:12], error); end
    return_credit(2'd3, 1);
    vec_cnt++; if (error !== 1'b1) begin err_cnt++; $display("FAIL overflow_error: got %b required 1", error); end
    vec_cnt++; if (credit_dbg[15:12] !== 4'd8) begin err_cnt++; $display("FAIL overflow_saturate: got %0d required 8", credit_dbg[15:12]); end
    repeat (3) tick();
    vec_cnt++; if (error !== 1'b1) begin err_cnt++; $display("FAIL overflow_sticky: got %b required 1", error); end
    vec_cnt++; if (credit_dbg !== 16'h8888) begin err_cnt++; $display("FAIL overflow_others: got %h required 8888", credit_dbg); end
  endtask

  task automatic test_backpressure();
    int idx;
    bit acc;
    rx_q.delete();
    for (int i = 0; i < 7; i++) push_word(64'h200 + 64'(i), (i == 6), 4'h1, 2'd0);
    wait_flits(8);
    repeat (3) tick();
    vec_cnt++; if (rx_q.size() !== 8 || credit_dbg[3:0] !== 4'd0) begin err_cnt++; $display("FAIL bp_drain: flits %0d credit %0d required 8 0", rx_q.size(), credit_dbg[3:0]); end
    rx_q.delete();
    idx = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      in_valid = 1'b1; in_data = 64'h300 + 64'(idx); in_last = (idx == 5);
      in_dest = (idx == 0) ? 4'h2 : 4'hF; in_vc = (idx == 0) ? 2'd0 : 2'd3;
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    vec_cnt++; if (idx !== 4) begin err_cnt++; $display("FAIL bp_accepted: got %0d words required 4", idx); end
    vec_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
    vec_cnt++; if (rx_q.size() !== 0) begin err_cnt++; $display("FAIL bp_no_flit: got %0d flits required 0", rx_q.size()); end
    for (int cyc = 0; cyc < 40; cyc++) begin
      in_valid = (idx < 6); in_data = 64'h300 + 64'(idx); in_last = (idx == 5);
      in_dest = 4'hF; in_vc = 2'd3;
      flow_ctrl_in = (cyc < 8) ? 3'b100 : 3'b000;
      @(negedge clk); acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    in_valid = 1'b0; flow_ctrl_in = 3'b000;
    wait_flits(7);
    vec_cnt++; if (idx !== 6 || rx_q.size() !== 7) begin err_cnt++; $display("FAIL bp_drain_count: words %0d flits %0d required 6 7", idx, rx_q.size()); end
    if (rx_q.size() >= 7) begin
      vec_cnt++; if (rx_q[0] !== {1'b0, head_flit(2'd0, 4'h2, 4'h3)}) begin err_cnt++; $display("FAIL bp_head: got %h required %h", rx_q[0], {1'b0, head_flit(2'd0, 4'h2, 4'h3)}); end
      for (int k = 1; k < 7; k++) begin
        vec_cnt++;
        if (rx_q[k] !== {(k == 6), body_flit((k == 6), 2'd0, 64'h300 + 64'(k - 1))}) begin
          err_cnt++; $display("FAIL bp_order%0d: got %h required %h", k, rx_q[k], {(k == 6), body_flit((k == 6), 2'd0, 64'h300 + 64'(k - 1))});
        end
      end
    end
    vec_cnt++; if (credit_dbg[3:0] !== 4'd1) begin err_cnt++; $display("FAIL bp_credit: got %0d required 1", credit_dbg[3:0]); end
    return_credit(2'd0, 7);
  endtask

  task automatic test_reset_mid();
    int k;
    rx_q.delete();
    push_word(64'h400, 1'b0, 4'h7, 2'd1);
    push_word(64'h401, 1'b0, 4'h7, 2'd1);
    push_word(64'h402, 1'b0, 4'h7, 2'd1);
    k = 0;
    while (!channel_out[69] && k < 10) begin tick(); k++; end
    vec_cnt++; if (channel_out[69] !== 1'b1) begin err_cnt++; $display("FAIL midrst_pre: valid %b required 1", channel_out[69]); end
    #2 reset = 1'b0;
    #1;
    vec_cnt++; if (channel_out !== 70'h0) begin err_cnt++; $display("FAIL midrst_async: got %h required 0", channel_out); end
    vec_cnt++; if (state_dbg !== 2'd0 || in_ready !== 1'b1 || error !== 1'b0) begin err_cnt++; $display("FAIL midrst_state: state %0d ready %b error %b required 0 1 0", state_dbg, in_ready, error); end
    @(posedge clk); #1;
    reset = 1'b1;
    tick();
    vec_cnt++; if (credit_dbg !== 16'h8888) begin err_cnt++; $display("FAIL midrst_credits: got %h required 8888", credit_dbg); end
    rx_q.delete();
    push_word(64'h55, 1'b1, 4'h6, 2'd0);
    wait_flits(2);
    repeat (2) tick();
    vec_cnt++; if (rx_q.size() !== 2) begin err_cnt++; $display("FAIL midrst_count: got %0d flits required 2", rx_q.size()); end
    if (rx_q.size() >= 2) begin
      vec_cnt++; if (rx_q[0] !== {1'b0, head_flit(2'd0, 4'h6, 4'h3)}) begin err_cnt++; $display("FAIL midrst_head: got %h required %h", rx_q[0], {1'b0, head_flit(2'd0, 4'h6, 4'h3)}); end
      vec_cnt++; if (rx_q[1] !== {1'b1, body_flit(1'b1, 2'd0, 64'h55)}) begin err_cnt++; $display("FAIL midrst_body: got %h required %h", rx_q[1], {1'b1, body_flit(1'b1, 2'd0, 64'h55)}); end
    end
  endtask

  initial begin
    reset = 1'b0; router_address = 4'd3; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    in_dest = '0; in_vc = '0; flow_ctrl_in = 3'b000;
    test_reset();
    test_single_word();
    test_credit_exhaust();
    test_simultaneous();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
